scad_byte_step: RTL and testbench
=================================

# scad_byte_step

Iterative byte-load shifter placed directly downstream of the step count adder in the KS-10 CPU. It accepts a byte position computed on the SCAD (P, in the SC format) and a byte size (S, from the byte pointer), and extracts the byte from a 36-bit data-path word. It shifts the word right one bit per enabled clock under a local step counter, masks the result to S bits, and returns it with a done strobe. This is the microcoded LDB path, moved off the main shifter so it can overlap other microcode work.

## Interface
- DWIDTH, 36, data word width (bits numbered 0 = MSB .. DWIDTH-1 = LSB)
- CWIDTH, 10, step-count width; matches the SCAD/SC width
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- clken  input  1  clock enable; state advances only on edges where clken=1
- start  input  1  request; sampled only in IDLE on a clken edge
- abort  input  1  cancel in-progress operation; sampled on clken edges
- pos  input  CWIDTH  byte position P (bit 0 is sign), SCAD format
- size  input  6  byte size S, unsigned
- din  input  DWIDTH  source word
- busy  output  1  high while an operation is in progress
- done  output  1  completion strobe
- dout  output  DWIDTH  extracted byte, right-justified, zero-filled
- perr  output  1  position error (P negative), valid with done

## Operation
- States: IDLE, SHIFT, DONE. Reset (rst=0) forces IDLE asynchronously, including mid-operation. It also clears busy, done, perr and dout to 0, the shift register to 0, the step counter to 0, and the captured size to 0.
- IDLE, start=1, clken=1: capture din into the shift register and size into the size register, load the step counter with N, set busy=1, go to SHIFT. Clear done and perr on this edge.
- N: if pos[0]=1, N=0 and perr is latched to 1. Otherwise N = min(pos, 36).
- SHIFT, per clken edge:
  - If the counter ≠ 0: logical right shift by 1 (zero into bit 0), decrement the counter.
  - If the counter = 0: dout = shreg AND mask(S), go to DONE.
  - mask(S) has the S least-significant bits set; S ≥ 36 gives all ones and S = 0 gives zero.
  - If perr is set, dout = 0 regardless of the data.
- DONE: done=1 and busy=0. On the next clken edge, clear done and go to IDLE. A start on that edge is ignored; start is accepted only from IDLE.
- abort=1 on a clken edge in SHIFT or DONE: go to IDLE and clear busy and done. dout keeps its previous value. abort has priority over the shift/finish action. abort in IDLE has no effect, and abort has priority over start.
- start while busy is ignored; there is no queueing.
- dout holds its value until the next completion or reset.
- The counter never underflows; it saturates at 0 by construction.
- A P+S that exceeds 36 needs no special case: high bits are zero-filled by the shift.

## Timing
- Edges below count only edges with clken=1. Edges with clken=0 freeze all state, and outputs hold.
- Accept edge E0: busy=1 after E0.
- Shifts occur on E1..EN. dout and done are updated on E(N+1); busy falls on the same edge.
- done stays high for exactly one enabled cycle and clears on E(N+2).
- Latency from the start edge to done is N+1 enabled edges: minimum 1 (P=0), maximum 37 (P≥36).
- The earliest next start is accepted on E(N+3), one enabled edge after done clears.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset assertion is immediate; deassertion is taken synchronously by the first following edge.

## Test plan
- Basic extract: din=36'o123456_701234, pos=6, size=6, start -> done after 7 enabled edges, dout=36'o000000_000012, perr=0, busy high for E0..E6 and low with done.
- Zero/limit: pos=0, size=36, din=36'o777777_000000 -> done after 1 edge, dout=din. Then pos=36, size=6 -> done after 37 edges, dout=0.
- Negative position: pos=10'b1000000101, size=8, din=all ones -> done after 1 edge, perr=1, dout=0. The next valid start clears perr on its accept edge.
- clken gating: same stimulus as the basic extract, with clken toggling 1,0,1,0… -> identical dout; done appears after 7 enabled edges (14 clocks) and holds while clken=0.
- Abort and start-while-busy:
  - pos=20, size=4, assert abort on enabled edge 5 -> IDLE, busy=0, done never pulses, dout unchanged.
  - Pulse start at E3 during a later run -> ignored, and the result matches an undisturbed run.
- Async reset mid-SHIFT: drive rst=0 between edges at count 10 -> busy, done, perr and dout go to 0 immediately. After release, the first start behaves normally.

Source files
------------

// File: rtl/scad_byte_step_if.sv
// Request/response bundle for the SCAD byte-load stepper: operands and controls in,
// extracted byte and status out.
interface scad_byte_step_if #(
    parameter int DWIDTH = 36,
    parameter int CWIDTH = 10
);
    logic              clken;
    logic              start;
    logic              abort;
    logic [CWIDTH-1:0] pos;
    logic [5:0]        size;
    logic [DWIDTH-1:0] din;
    logic              busy;
    logic              done;
    logic              perr;
    logic [DWIDTH-1:0] dout;

    modport master (output clken, start, abort, pos, size, din,
                    input  busy, done, perr, dout);
    modport slave  (input  clken, start, abort, pos, size, din,
                    output busy, done, perr, dout);
endinterface

// File: rtl/scad_byte_step.sv
// Iterative LDB byte extractor: shifts the captured word right one bit per enabled
// clock under a step counter loaded from the SCAD position, then masks to the byte size.
module scad_byte_step #(
    parameter int DWIDTH = 36,
    parameter int CWIDTH = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    scad_byte_step_if.slave    bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam logic [CWIDTH-1:0] DW_C = CWIDTH'(DWIDTH);

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] shreg_q, shreg_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [5:0]        size_q, size_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic [DWIDTH-1:0] dout_q, dout_d;

    logic [DWIDTH-1:0] mask;
    logic [CWIDTH-1:0] n_load;
    logic              pos_neg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        // Sign of P is its most significant bit (bit 0 in KS-10 numbering).
        pos_neg = bus.pos[CWIDTH-1];
        n_load  = pos_neg ? '0 : ((bus.pos > DW_C) ? DW_C : bus.pos);
        mask    = '0;
        for (int i = 0; i < DWIDTH; i++) mask[i] = (int'(size_q) > i);

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        busy_d  = busy_q;
        done_d  = done_q;
        perr_d  = perr_q;
        dout_d  = dout_q;

        if (bus.clken) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        shreg_d = bus.din;
                        size_d  = bus.size;
                        cnt_d   = n_load;
                        perr_d  = pos_neg;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.abort) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (cnt_q != '0) begin
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q - CWIDTH'(1);
                    end else begin
                        dout_d  = perr_q ? '0 : (shreg_q & mask);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.perr = perr_q;
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_scad_byte_step.sv
// Bench for scad_byte_step: directed vector table, clken-gating, abort, start-while-busy,
// async reset, and randomized operations against an arithmetic reference model.
module tb_scad_byte_step;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [35:0] last_dout = '0;

    always #5 clk = ~clk;

    scad_byte_step_if #(.DWIDTH(36), .CWIDTH(10)) bus ();

    scad_byte_step #(.DWIDTH(36), .CWIDTH(10)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [35:0] din;
        logic [9:0]  pos;
        logic [5:0]  size;
        logic [35:0] dout;
        logic        perr;
        int          lat;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: P negative -> error; else byte = (word >> min(P,36)) masked to S bits.
    function automatic void model(input logic [35:0] d, input logic [9:0] p, input logic [5:0] s,
                                  output logic [35:0] o, output logic pe, output int lat);
        int n;
        logic [35:0] m;
        if (p[9]) begin
            pe = 1'b1; o = '0; lat = 1;
        end else begin
            n   = (int'(p) > 36) ? 36 : int'(p);
            m   = (s >= 6'd36) ? '1 : 36'((64'd1 << s) - 64'd1);
            o   = (d >> n) & m;
            pe  = 1'b0;
            lat = n + 1;
        end
    endfunction

    // mode: 0 = clken always high, 1 = alternating, 2 = random
    task automatic do_op(input string nm, input logic [35:0] d, input logic [9:0] p,
                         input logic [5:0] s, input int mode, input logic [35:0] edout,
                         input logic eperr, input int elat);
        int lat, cyc;
        logic en, busy_ok;
        @(negedge clk);
        bus.din = d; bus.pos = p; bus.size = s; bus.start = 1'b1; bus.clken = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, "_busy_after_accept"}, bus.busy, 1);
        chk({nm, "_perr_after_accept"}, bus.perr, eperr);
        lat = 0; cyc = 0; busy_ok = 1'b1;
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            case (mode)
                1: bus.clken = ~bus.clken;
                2: bus.clken = 1'($urandom_range(0, 1));
                default: bus.clken = 1'b1;
            endcase
            en = bus.clken;
            @(posedge clk); #1;
            cyc++;
            if (en) lat++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        chk({nm, "_done"}, bus.done, 1);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_dout"}, bus.dout, edout);
        chk({nm, "_perr"}, bus.perr, eperr);
        chk({nm, "_busy_with_done"}, bus.busy, 0);
        chk({nm, "_busy_during"}, busy_ok, 1);
        if (mode == 1) begin
            @(negedge clk); bus.clken = 1'b0;
            @(posedge clk); #1;
            chk({nm, "_done_hold_gated"}, bus.done, 1);
        end
        @(negedge clk); bus.clken = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done_clears"}, bus.done, 0);
        chk({nm, "_dout_holds"}, bus.dout, edout);
        last_dout = edout;
    endtask

    initial begin
        logic [35:0] rd, eo;
        logic [9:0]  rp;
        logic [5:0]  rs;
        logic        ep, saw;
        int          el, cyc;

        vt[0] = '{36'o123456_701234, 10'd6,  6'd6,  36'o000000_000012, 1'b0, 7};
        vt[1] = '{36'o777777_000000, 10'd0,  6'd36, 36'o777777_000000, 1'b0, 1};
        vt[2] = '{36'o777777_000000, 10'd36, 6'd6,  36'o0,              1'b0, 37};
        vt[3] = '{36'o777777_777777, 10'b1000000101, 6'd8, 36'o0,       1'b1, 1};
        vt[4] = '{36'o123456_701234, 10'd12, 6'd12, 36'o5670,           1'b0, 13};
        vt[5] = '{36'o777777_777777, 10'd30, 6'd12, 36'o77,             1'b0, 31};
        vt[6] = '{36'o000000_000777, 10'd2,  6'd0,  36'o0,              1'b0, 3};
        vt[7] = '{36'o777777_777777, 10'd100, 6'd36, 36'o0,             1'b0, 37};

        bus.clken = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.pos = '0; bus.size = '0; bus.din = '0;
        #12;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_perr", bus.perr, 0);
        chk("reset_dout", bus.dout, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vt[i].din, vt[i].pos, vt[i].size, 0,
                  vt[i].dout, vt[i].perr, vt[i].lat);

        do_op("gated", vt[0].din, vt[0].pos, vt[0].size, 1, vt[0].dout, 1'b0, 7);

        // Abort on enabled edge 5 of a pos=20 run
        @(negedge clk);
        bus.din = 36'o765432_123456; bus.pos = 10'd20; bus.size = 6'd4;
        bus.start = 1'b1; bus.clken = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); bus.abort = 1'b1;
        @(posedge clk); #1; bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_dout", bus.dout, last_dout);
        saw = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (bus.done) saw = 1'b1; end
        chk("abort_no_done", saw, 0);
        chk("abort_dout_later", bus.dout, last_dout);

        // Start pulse at E3 of a busy run must be ignored
        rd = 36'o135724_602413;
        model(rd, 10'd16, 6'd8, eo, ep, el);
        @(negedge clk);
        bus.din = rd; bus.pos = 10'd16; bus.size = 6'd8; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); bus.start = 1'b1; bus.din = '1; bus.pos = 10'd0; bus.size = 6'd36;
        @(posedge clk); #1; bus.start = 1'b0;
        cyc = 3;
        while (!bus.done && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("sbusy_latency", cyc, el);
        chk("sbusy_dout", bus.dout, eo);
        @(posedge clk); #1;
        last_dout = eo;

        // Async reset mid-SHIFT, between edges
        @(negedge clk);
        bus.din = 36'o777777_777777; bus.pos = 10'd20; bus.size = 6'd10; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_perr", bus.perr, 0);
        chk("arst_dout", bus.dout, 0);
        @(negedge clk); rst_n = 1'b1;
        do_op("post_reset", vt[4].din, vt[4].pos, vt[4].size, 0, vt[4].dout, 1'b0, 13);

        // Randomized operations with random clken
        for (int i = 0; i < 40; i++) begin
            rd = {4'($urandom), 32'($urandom)};
            rs = 6'($urandom);
            case ($urandom_range(0, 3))
                0: rp = 10'($urandom_range(0, 150) * 2);
                1: rp = {1'b1, 9'($urandom)} | 10'd1;
                default: rp = 10'($urandom_range(0, 23) * 2);
            endcase
            model(rd, rp, rs, eo, ep, el);
            do_op($sformatf("rnd%0d", i), rd, rp, rs, (i % 2 == 0) ? 2 : 0, eo, ep, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
